// File: rtl/alu_ctrl_sequencer_if.sv
// Handshake bundle between main control, the ALU control sequencer and the ALU.
// The slave modport is the sequencer's view; master is the driver/consumer side.
interface alu_ctrl_sequencer_if #(
  parameter int FUNCT_W = 5,
  parameter int OP_W    = 2,
  parameter int CTRL_W  = 2,
  parameter int MC_LAT  = 4
);
  localparam int CNT_W = $clog2(MC_LAT + 1);

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [OP_W-1:0]    aluop;
  logic [FUNCT_W-1:0] funct;
  logic               out_valid;
  logic               out_ready;
  logic [CTRL_W-1:0]  alu_ctrl;
  logic               multi_cycle;
  logic               busy;
  logic [CNT_W-1:0]   count;

  modport slave (
    input  flush, in_valid, aluop, funct, out_ready,
    output in_ready, out_valid, alu_ctrl, multi_cycle, busy, count
  );

  modport master (
    output flush, in_valid, aluop, funct, out_ready,
    input  in_ready, out_valid, alu_ctrl, multi_cycle, busy, count
  );
endinterface

// File: rtl/alu_ctrl_sequencer.sv
// Registered ALU control decoder with a multi-cycle (iterative shift/multiply)
// countdown and valid/ready handshakes on both sides.
module alu_ctrl_sequencer #(
  parameter int FUNCT_W = 5,
  parameter int OP_W    = 2,
  parameter int CTRL_W  = 2,
  parameter int MC_LAT  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_ctrl_sequencer_if.slave   bus
);
  localparam int CNT_W = $clog2(MC_LAT + 1);

  if (CTRL_W < OP_W || CTRL_W > FUNCT_W - 1 || MC_LAT < 1) begin : g_bad_params
    $error("alu_ctrl_sequencer: illegal FUNCT_W/OP_W/CTRL_W/MC_LAT combination");
  end

  typedef enum logic [1:0] {IDLE, WAIT, OUT} state_e;

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              multi_q, multi_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              accept;
  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_multi;

  assign bus.in_ready = !bus.flush &&
                        (state_q == IDLE || (state_q == OUT && bus.out_ready));
  assign accept       = bus.in_valid && bus.in_ready;

  // Opcode MSB low: opcode passes straight through; high: decode from funct.
  assign dec_ctrl  = bus.aluop[OP_W-1] ? bus.funct[CTRL_W-1:0] : CTRL_W'(bus.aluop);
  assign dec_multi = bus.aluop[OP_W-1] && bus.funct[FUNCT_W-1];

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    multi_d = multi_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: ;
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = OUT;
      end
      OUT: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A new op overrides the IDLE hold and the OUT drain (back-to-back).
    if (accept) begin
      ctrl_d  = dec_ctrl;
      multi_d = dec_multi;
      if (dec_multi) begin
        state_d = WAIT;
        cnt_d   = CNT_W'(MC_LAT);
      end else begin
        state_d = OUT;
        cnt_d   = '0;
      end
    end

    if (bus.flush) begin
      state_d = IDLE;
      ctrl_d  = '0;
      multi_d = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      multi_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      multi_q <= multi_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_valid   = (state_q == OUT);
  assign bus.busy        = (state_q == WAIT);
  assign bus.alu_ctrl    = ctrl_q;
  assign bus.multi_cycle = multi_q;
  assign bus.count       = cnt_q;
endmodule

// File: doc/alu_ctrl_sequencer.md
Name: alu_ctrl_sequencer

Overview:
- Parametrised, registered successor to the combinational ALU control decoder.
- Decodes the main-control ALU opcode and the instruction funct field into the ALU control code.
- Adds a multi-cycle operation class (iterative shift/multiply) with a countdown and busy/stall output.
- Has valid/ready handshakes on both sides and sits between the control unit and the ALU in the phase-2 datapath.

Parameters:
- FUNCT_W, 5, funct field width. MSB is the multi-cycle class flag.
- OP_W, 2, ALU opcode width from main control. MSB selects funct decode.
- CTRL_W, 2, ALU control code width. Legal only if OP_W <= CTRL_W <= FUNCT_W-1; otherwise elaboration error.
- MC_LAT, 4, number of busy cycles for a multi-cycle op. Must be >= 1.
- CNT_W, $clog2(MC_LAT+1), countdown width. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort; clears all state
- in_valid  input  1  aluop/funct valid
- in_ready  output  1  block accepts this cycle (combinational)
- aluop  input  OP_W  ALU opcode from main control
- funct  input  FUNCT_W  instruction funct field
- out_valid  output  1  alu_ctrl is final and consumable
- out_ready  input  1  ALU/writeback consumes result
- alu_ctrl  output  CTRL_W  registered ALU control code
- multi_cycle  output  1  registered: current op is multi-cycle
- busy  output  1  multi-cycle op in progress (pipeline stall)
- count  output  CNT_W  remaining busy cycles (0 when not busy)

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; alu_ctrl=0, multi_cycle=0, out_valid=0, busy=0, count=0.
- States:
  - IDLE: nothing held.
  - WAIT: multi-cycle countdown.
  - OUT: result held, out_valid=1.
- busy = (state==WAIT). out_valid = (state==OUT).
- in_ready = !flush && (state==IDLE || (state==OUT && out_ready)). It is 0 throughout WAIT.
- Accept = in_valid && in_ready. On the accept edge:
  - ctrl_d = aluop[OP_W-1]==0 ? aluop zero-extended to CTRL_W : funct[CTRL_W-1:0].
  - multi_d = aluop[OP_W-1] && funct[FUNCT_W-1].
  - alu_ctrl<=ctrl_d; multi_cycle<=multi_d.
- Single op (multi_d=0): next state OUT. out_valid is high in the cycle after accept (latency 1).
- Multi op (multi_d=1): next state WAIT with count=MC_LAT.
  - count decrements by 1 each cycle.
  - At the edge where count==1: count<=0 and state<=OUT.
  - busy is high for exactly MC_LAT cycles. out_valid rises MC_LAT+1 cycles after the accept edge.
  - alu_ctrl is valid and stable throughout WAIT so the ALU can iterate.
- OUT with out_ready=0: hold. alu_ctrl, multi_cycle and out_valid stay stable.
- OUT with out_ready=1 and accept: back-to-back; load the new op per the rules above (no bubble).
- OUT with out_ready=1 and no accept: next state IDLE. out_valid=0; alu_ctrl and multi_cycle retain their last value.
- IDLE with no accept: hold.
- flush=1 at a clock edge: state IDLE; alu_ctrl=0, multi_cycle=0, count=0. No accept that cycle. flush overrides all other transitions.
- rst_n is asserted asynchronously mid-WAIT or mid-OUT: all outputs go to reset values immediately. The first accept is possible on the first edge after rst_n rises.
- aluop/funct are sampled only on accept. Changes at any other time have no effect.

Test Plan:
- Reset: rst_n=0 with random inputs -> alu_ctrl=0, out_valid=0, busy=0, count=0, in_ready=1 after release.
- Opcode passthrough: aluop=2'b01, funct=5'b10011, in_valid pulse, out_ready=1 -> next cycle out_valid=1, alu_ctrl=2'b01, multi_cycle=0; following cycle out_valid=0.
- Funct decode, back-to-back: aluop=2'b10 with funct=5'b00011 then funct=5'b00010 on consecutive cycles, out_ready=1 -> alu_ctrl 2'b11 then 2'b10 on consecutive cycles, no bubble.
- Multi-cycle: aluop=2'b10, funct=5'b10010 -> busy cycles 1-4 with count 4,3,2,1, in_ready=0, alu_ctrl=2'b10 throughout; out_valid=1 at cycle 5, multi_cycle=1.
- Backpressure: single op with out_ready=0 for 3 cycles -> out_valid and alu_ctrl held stable, in_ready=0; out_ready=1 -> IDLE next cycle.
- Flush then async reset: flush=1 at count=2 -> next cycle IDLE, busy=0, alu_ctrl=0, no out_valid. Repeat with rst_n low mid-WAIT -> outputs clear without a clock edge.
